// File: rtl/avmm_reg_responder.sv
// avmm_reg_responder
//   Avalon-MM responder terminating the power-sequencer command stream.
//   Slots 0..P_NUMREGS-2 are R/W control registers and slot P_NUMREGS-1
//   mirrors STATUS_IN (read-only). Every transfer is stretched by
//   P_WAITCYCLES wait states. After that comes a single-cycle acknowledge.
//
// Ports
//   CLOCK, RESET_N         clock, async active-low reset
//   AVS_S0_READ/WRITE      command strobes, held by the master until acked
//   AVS_S0_ADDRESS         word address
//   AVS_S0_WRITEDATA       write data
//   AVS_S0_READDATA        read data, non-zero only in the ack cycle
//   AVS_S0_WAITREQUEST     low for exactly the ack cycle
//   STATUS_IN              registered into the top slot every cycle
//   REG_OUT                all slots flattened, slot k at [k*P_DATASIZE +: P_DATASIZE]
//   PROTO_ERR              sticky: withdrawn request or READ&WRITE together
module avmm_reg_responder #(
  parameter int P_ADDRSIZE   = 8,
  parameter int P_DATASIZE   = 32,
  parameter int P_NUMREGS    = 16,
  parameter int P_WAITCYCLES = 2
) (
  input  logic                            CLOCK,
  input  logic                            RESET_N,
  input  logic                            AVS_S0_READ,
  input  logic                            AVS_S0_WRITE,
  input  logic [P_ADDRSIZE-1:0]           AVS_S0_ADDRESS,
  input  logic [P_DATASIZE-1:0]           AVS_S0_WRITEDATA,
  output logic [P_DATASIZE-1:0]           AVS_S0_READDATA,
  output logic                            AVS_S0_WAITREQUEST,
  input  logic [P_DATASIZE-1:0]           STATUS_IN,
  output logic [P_NUMREGS*P_DATASIZE-1:0] REG_OUT,
  output logic                            PROTO_ERR
);

  localparam int                CNT_W     = (P_WAITCYCLES > 0) ? $clog2(P_WAITCYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(P_WAITCYCLES);
  localparam int                STAT_SLOT = P_NUMREGS - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  // Command captured in ST_IDLE; the bus is not re-sampled afterwards
  // except to detect a withdrawn request.
  typedef struct packed {
    logic                  wr;
    logic [P_ADDRSIZE-1:0] addr;
    logic [P_DATASIZE-1:0] data;
  } req_t;

  state_t                               state, state_nxt;
  req_t                                 req;
  logic [CNT_W-1:0]                     cnt;
  logic                                 proto_err_q;
  logic [P_NUMREGS-1:0][P_DATASIZE-1:0] regs;
  logic                                 req_vld;
  logic                                 wr_ack;

  assign req_vld = AVS_S0_READ | AVS_S0_WRITE;
  assign wr_ack  = (state == ST_ACK) && req.wr;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_vld) state_nxt = (P_WAITCYCLES > 0) ? ST_WAIT : ST_ACK;
      // Withdrawal wins over the final countdown step.
      ST_WAIT: begin
        if (!req_vld)                 state_nxt = ST_IDLE;
        else if (cnt == CNT_W'(1))    state_nxt = ST_ACK;
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Read data is muxed purely from registers (state, latched address,
  // slot contents), so no bus input reaches READDATA combinationally.
  // Out-of-range addresses match no slot and read back 0.
  always_comb begin
    AVS_S0_WAITREQUEST = 1'b1;
    AVS_S0_READDATA    = '0;
    if (state == ST_ACK) begin
      AVS_S0_WAITREQUEST = 1'b0;
      if (!req.wr) begin
        for (int k = 0; k < P_NUMREGS; k++)
          if (req.addr == P_ADDRSIZE'(k)) AVS_S0_READDATA = regs[k];
      end
    end
  end

  // ---------------- request latch, wait counter, error flag ----------------
  // The counter only loads in ST_IDLE, so it never wraps.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      req         <= '0;
      cnt         <= '0;
      proto_err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req_vld) begin
          // READ+WRITE together is executed as a write.
          req <= '{wr: AVS_S0_WRITE, addr: AVS_S0_ADDRESS, data: AVS_S0_WRITEDATA};
          cnt <= WAIT_LOAD;
          if (AVS_S0_READ && AVS_S0_WRITE) proto_err_q <= 1'b1;
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (!req_vld) proto_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- register bank ----------------
  // Writes land on the edge that ends the ack cycle. The status slot
  // ignores writes and follows STATUS_IN one cycle late.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      regs <= '0;
    end else begin
      for (int k = 0; k < STAT_SLOT; k++)
        if (wr_ack && req.addr == P_ADDRSIZE'(k)) regs[k] <= req.data;
      regs[STAT_SLOT] <= STATUS_IN;
    end
  end

  assign REG_OUT   = regs;
  assign PROTO_ERR = proto_err_q;

endmodule

// File: tb/tb_avmm_reg_responder.sv
// tb_avmm_reg_responder
//   Random and directed transfers against a register-array model.
//   Instance u_dut uses 2 wait states; u_dut0 uses 0 wait states.
module tb_avmm_reg_responder;
  localparam int AW = 8, DW = 32, NR = 16, W = 2;
  localparam int RW = NR * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          rd, wr, wq, perr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata, status_in;
  logic [RW-1:0] reg_out;

  logic          rd0, wr0, wq0, perr0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0, rdata0;
  logic [RW-1:0] reg_out0;

  avmm_reg_responder #(.P_ADDRSIZE(AW), .P_DATASIZE(DW), .P_NUMREGS(NR), .P_WAITCYCLES(W)) u_dut (
    .CLOCK(clk), .RESET_N(rst_n), .AVS_S0_READ(rd), .AVS_S0_WRITE(wr),
    .AVS_S0_ADDRESS(addr), .AVS_S0_WRITEDATA(wdata), .AVS_S0_READDATA(rdata),
    .AVS_S0_WAITREQUEST(wq), .STATUS_IN(status_in), .REG_OUT(reg_out), .PROTO_ERR(perr));

  avmm_reg_responder #(.P_ADDRSIZE(AW), .P_DATASIZE(DW), .P_NUMREGS(NR), .P_WAITCYCLES(0)) u_dut0 (
    .CLOCK(clk), .RESET_N(rst_n), .AVS_S0_READ(rd0), .AVS_S0_WRITE(wr0),
    .AVS_S0_ADDRESS(addr0), .AVS_S0_WRITEDATA(wdata0), .AVS_S0_READDATA(rdata0),
    .AVS_S0_WAITREQUEST(wq0), .STATUS_IN(status_in), .REG_OUT(reg_out0), .PROTO_ERR(perr0));

  int n_vec = 0, n_err = 0;

  // model: contents of the R/W slots and the sticky error flag
  logic [DW-1:0] m_regs [NR-1];
  bit            m_err;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < NR-1; k++) m_regs[k] = '0;
    m_err = 1'b0;
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (int'(a) < NR-1)  return m_regs[a[3:0]];
    if (int'(a) == NR-1) return status_in;
    return '0;
  endfunction

  function automatic logic [RW-1:0] m_regout();
    logic [RW-1:0] v;
    for (int k = 0; k < NR-1; k++) v[k*DW +: DW] = m_regs[k];
    v[(NR-1)*DW +: DW] = status_in;
    return v;
  endfunction

  // One complete transfer on u_dut. Called at a negedge with the DUT idle;
  // returns at a negedge with the DUT idle again.
  task automatic xfer(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int            cyc;
    bit            acked;
    logic [DW-1:0] exp_rd;
    exp_rd = m_read(a);
    rd = r; wr = w; addr = a; wdata = d;
    cyc = 0; acked = 0;
    while (!acked && cyc < 20) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (!wq) acked = 1;
    end
    chk("latency", cyc, W + 1);
    if (acked && r && !w) chk("rdata", rdata, exp_rd);
    rd = 0; wr = 0;
    if (w) begin
      if (r) m_err = 1'b1;
      if (int'(a) < NR-1) m_regs[a[3:0]] = d;
    end
    @(posedge clk); @(negedge clk);
    chk("reg_out", reg_out, m_regout());
    chk("proto_err", perr, m_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d0 [4];
    int            sel;
    logic [AW-1:0] a;

    rst_n = 0; status_in = '0;
    rd = 0; wr = 0; addr = '0; wdata = '0;
    rd0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_wq",      wq,       1);
    chk("rst_rdata",   rdata,    0);
    chk("rst_perr",    perr,     0);
    chk("rst_regout",  reg_out,  0);
    chk("rst_wq0",     wq0,      1);
    chk("rst_regout0", reg_out0, 0);
    rst_n = 1;
    @(negedge clk);

    // basic read, write/readback
    xfer(1, 0, 8'd3, '0);
    xfer(0, 1, 8'd5, 32'hA5A5_0001);
    xfer(1, 0, 8'd5, '0);
    chk("slot5", reg_out[191:160], 32'hA5A5_0001);

    // status slot is read-only
    status_in = 32'h1234_5678;
    @(negedge clk);
    xfer(1, 0, 8'd15, '0);
    xfer(0, 1, 8'd15, 32'hFFFF_FFFF);
    xfer(1, 0, 8'd15, '0);

    // out of range
    xfer(0, 1, 8'd200, 32'hDEAD_BEEF);
    xfer(1, 0, 8'd200, '0);

    // withdrawn write during wait states
    wr = 1; addr = 8'd2; wdata = 32'h7777_7777;
    @(posedge clk); @(negedge clk);
    chk("wd_wq", wq, 1);
    wr = 0;
    @(posedge clk); @(negedge clk);
    chk("wd_perr", perr, 1);
    chk("wd_wq2", wq, 1);
    chk("wd_regout", reg_out, m_regout());
    m_err = 1'b1;
    xfer(1, 0, 8'd2, '0);

    // READ+WRITE together executes as a write
    xfer(1, 1, 8'd9, 32'h5555_AAAA);
    xfer(1, 0, 8'd9, '0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0) status_in = $urandom;
      a = ($urandom_range(7) == 0) ? AW'($urandom_range(255, 16)) : AW'($urandom_range(15));
      sel = $urandom_range(19);
      if (sel < 9)       xfer(1, 0, a, '0);
      else if (sel < 18) xfer(0, 1, a, $urandom);
      else               xfer(1, 1, a, $urandom);
    end

    // zero wait states: back-to-back writes then reads, ack every 2nd cycle
    for (int i = 0; i < 4; i++) d0[i] = $urandom;
    wr0 = 1; addr0 = '0; wdata0 = d0[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("b2b_wr_ack", wq0, 0);
      if (i < 3) begin addr0 = AW'(i + 1); wdata0 = d0[i+1]; end
      else wr0 = 0;
      @(posedge clk); @(negedge clk);
      chk("b2b_wr_idle", wq0, 1);
    end
    for (int i = 0; i < 4; i++) chk("b2b_slot", reg_out0[i*DW +: DW], d0[i]);
    rd0 = 1; addr0 = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("b2b_rd_ack", wq0, 0);
      chk("b2b_rdata", rdata0, d0[i]);
      if (i < 3) addr0 = AW'(i + 1);
      else rd0 = 0;
      @(posedge clk); @(negedge clk);
      chk("b2b_rd_idle", wq0, 1);
    end
    chk("b2b_perr", perr0, 0);

    // reset in the middle of a write's wait states
    wr = 1; addr = 8'd7; wdata = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_wq", wq, 1);
    chk("mid_rst_regout", reg_out, 0);
    chk("mid_rst_perr", perr, 0);
    chk("mid_rst_rdata", rdata, 0);
    wr = 0;
    m_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    xfer(1, 0, 8'd7, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
